// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: shared widths, size/state encodings and span helper for the load/store unit
package mem_access_unit_pkg;
  localparam int WordBus = 32;
  localparam int MemAddrBus = 32;
  localparam logic [WordBus-1:0] ZERO_WORD = '0;
  typedef enum logic [1:0] {SizeByte = 2'd0, SizeHalf = 2'd1, SizeWord = 2'd2, SizeBad = 2'd3} size_e;
  typedef enum logic [1:0] {IDLE, FIRST, SECOND, RESP} state_e;
  function automatic logic spans(input logic [1:0] off, input logic [1:0] size);
    return ({1'b0, off} + (3'd1 << size)) > 3'd4;
  endfunction
endpackage

// File: rtl/mem_access_unit_lane_align.sv
// lsu_lane_align: byte-lane strobes, shifted store data and load assembly/extension
// Ports: off/size/is_unsigned/phase select the lanes; wdata is right-justified store data;
// rdata is the RAM word; acc is the bytes assembled so far; sel/wlane drive the RAM write;
// merged is acc updated with this phase's lanes; ext is acc sign/zero-extended to a word.
module lsu_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]         off,
  input  logic [1:0]         size,
  input  logic               is_unsigned,
  input  logic               phase,
  input  logic [WordBus-1:0] wdata,
  input  logic [WordBus-1:0] rdata,
  input  logic [WordBus-1:0] acc,
  output logic [3:0]         sel,
  output logic [WordBus-1:0] wlane,
  output logic [WordBus-1:0] merged,
  output logic [WordBus-1:0] ext
);
  logic [3:0] mask;
  logic [5:0] sh;
  logic [7:0] sel_w;
  logic [2*WordBus-1:0] data_w;
  assign mask = size == SizeByte ? 4'b0001 : size == SizeHalf ? 4'b0011 : 4'b1111;
  assign sh = {1'b0, off, 3'b000};
  // Shifting into a two-word window makes the upper half the second access of a split
  assign sel_w = {4'b0000, mask} << off;
  assign data_w = {ZERO_WORD, wdata} << sh;
  assign sel = phase ? sel_w[7:4] : sel_w[3:0];
  assign wlane = phase ? data_w[63:32] : data_w[31:0];
  assign merged = phase ? acc | (rdata << (6'd32 - sh)) : rdata >> sh;
  assign ext = size == SizeByte ? {{24{~is_unsigned & acc[7]}}, acc[7:0]} :
               size == SizeHalf ? {{16{~is_unsigned & acc[15]}}, acc[15:0]} : acc;
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: byte/half/word load-store initiator for the word-wide data RAM port
// Ports: req_* request handshake from the memory stage; rsp_* response handshake with
// extended load data and error; mem_* word-aligned RAM port with byte strobes.
// Macro BUCEROS_LSU_MISALIGN_EN: split word-boundary-spanning accesses into two RAM
// accesses; when undefined such accesses respond immediately with rsp_err_o = 1.
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [MemAddrBus-1:0] req_addr_i,
  input  logic [WordBus-1:0]    req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [WordBus-1:0]    rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic [MemAddrBus-1:0] mem_addr_o,
  output logic                  mem_w_en_o,
  output logic [3:0]            mem_w_sel_o,
  output logic [WordBus-1:0]    mem_w_data_o,
  input  logic [WordBus-1:0]    mem_r_data_i
);
  state_e state, state_n;
  logic we_q, uns_q, err_q;
  logic [1:0] size_q;
  logic [MemAddrBus-1:0] addr_q;
  logic [WordBus-1:0] wdata_q, rdata_q;
  logic accept, req_bad, act, phase;
  logic [3:0] sel;
  logic [WordBus-1:0] wlane, merged, ext;
  assign accept = req_valid_i & req_ready_o;
  assign act = state == FIRST || state == SECOND;
`ifdef BUCEROS_LSU_MISALIGN_EN
  logic span;
  assign span = spans(addr_q[1:0], size_q);
  assign phase = state == SECOND;
  assign req_bad = req_size_i == SizeBad;
`else
  assign phase = 1'b0;
  assign req_bad = req_size_i == SizeBad || spans(req_addr_i[1:0], req_size_i);
`endif
  lsu_lane_align u_align (
    .off        (addr_q[1:0]),
    .size       (size_q),
    .is_unsigned(uns_q),
    .phase      (phase),
    .wdata      (wdata_q),
    .rdata      (mem_r_data_i),
    .acc        (rdata_q),
    .sel        (sel),
    .wlane      (wlane),
    .merged     (merged),
    .ext        (ext)
  );
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = accept ? (req_bad ? RESP : FIRST) : IDLE;
`ifdef BUCEROS_LSU_MISALIGN_EN
      FIRST:   state_n = span ? SECOND : RESP;
      SECOND:  state_n = RESP;
`else
      FIRST:   state_n = RESP;
`endif
      RESP:    state_n = rsp_ready_i ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      we_q <= 1'b0;
      uns_q <= 1'b0;
      err_q <= 1'b0;
      size_q <= 2'd0;
      addr_q <= '0;
      wdata_q <= ZERO_WORD;
      rdata_q <= ZERO_WORD;
    end else begin
      state <= state_n;
      if (accept) begin
        we_q <= req_we_i;
        uns_q <= req_unsigned_i;
        err_q <= req_bad;
        size_q <= req_size_i;
        addr_q <= req_addr_i;
        wdata_q <= req_wdata_i;
        rdata_q <= ZERO_WORD;
      end
      if (act && !we_q) rdata_q <= merged;
    end
  end
  assign req_ready_o = state == IDLE && !rst;
  assign rsp_valid_o = state == RESP;
  assign rsp_err_o = state == RESP && err_q;
  assign rsp_rdata_o = state == RESP && !we_q && !err_q ? ext : ZERO_WORD;
  assign mem_addr_o = act ? {addr_q[MemAddrBus-1:2], 2'b00} + {29'd0, phase, 2'b00} : '0;
  assign mem_w_en_o = act && we_q;
  assign mem_w_sel_o = mem_w_en_o ? sel : 4'b0000;
  assign mem_w_data_o = mem_w_en_o ? wlane : ZERO_WORD;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench with a RAM model for mem_access_unit
module tb_mem_access_unit;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid_i = 1'b0, req_we_i = 1'b0, req_unsigned_i = 1'b0, rsp_ready_i = 1'b0;
  logic [1:0] req_size_i = 2'd0;
  logic [31:0] req_addr_i = '0, req_wdata_i = '0;
  logic req_ready_o, rsp_valid_o, rsp_err_o, mem_w_en_o;
  logic [31:0] rsp_rdata_o, mem_addr_o, mem_w_data_o, mem_r_data_i;
  logic [3:0] mem_w_sel_o;
  logic [31:0] ram [0:1023];
  int wen_cnt = 0;
  int npass = 0, ntot = 0;
  int lat, acc_wait;
  logic [31:0] got_rdata;
  logic got_err;
  logic [31:0] a_addr [2];
  logic [3:0] a_sel [2];
  logic [31:0] a_data [2];
  logic a_wen [2];
  typedef struct {logic [31:0] rdata; logic err; int lat;} exp_t;
  exp_t sb[$];
  exp_t e;
`ifdef BUCEROS_LSU_MISALIGN_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  mem_access_unit dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o), .mem_addr_o(mem_addr_o),
    .mem_w_en_o(mem_w_en_o), .mem_w_sel_o(mem_w_sel_o), .mem_w_data_o(mem_w_data_o),
    .mem_r_data_i(mem_r_data_i)
  );

  always #5 clk = ~clk;
  assign mem_r_data_i = ram[mem_addr_o[11:2]];
  always @(posedge clk) begin
    if (mem_w_en_o) begin
      wen_cnt <= wen_cnt + 1;
      for (int k = 0; k < 4; k++)
        if (mem_w_sel_o[k]) ram[mem_addr_o[11:2]][8*k +: 8] <= mem_w_data_o[8*k +: 8];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1);
  end

  task automatic send_req(input logic we, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd);
    req_we_i = we; req_size_i = sz; req_unsigned_i = u; req_addr_i = a; req_wdata_i = wd;
    req_valid_i = 1'b1;
    acc_wait = 0;
    while (!req_ready_o && acc_wait < 20) begin @(posedge clk); #1; acc_wait++; end
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    for (int i = 0; i < 2; i++) begin a_addr[i] = '0; a_sel[i] = '0; a_data[i] = '0; a_wen[i] = 1'b0; end
    lat = 1;
    while (!rsp_valid_o && lat < 20) begin
      if (lat <= 2) begin
        a_addr[lat-1] = mem_addr_o; a_sel[lat-1] = mem_w_sel_o;
        a_data[lat-1] = mem_w_data_o; a_wen[lat-1] = mem_w_en_o;
      end
      @(posedge clk); #1;
      lat++;
    end
    got_rdata = rsp_rdata_o;
    got_err = rsp_err_o;
  endtask

  task automatic finish_rsp;
    rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    rsp_ready_i = 1'b0;
  endtask

  task automatic xfer(input logic we, input logic [1:0] sz, input logic u, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] er, input logic ee, input int el);
    sb.push_back('{rdata: er, err: ee, lat: el});
    send_req(we, sz, u, a, wd);
    e = sb.pop_front();
  endtask

  task automatic store_word(input logic [31:0] a, input logic [31:0] d);
    send_req(1'b1, 2'd2, 1'b0, a, d);
    finish_rsp();
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    ntot++; if (req_ready_o !== 1'b0) $display("FAIL rst_req_ready got %b exp 0", req_ready_o); else npass++;
    ntot++; if (rsp_valid_o !== 1'b0) $display("FAIL rst_rsp_valid got %b exp 0", rsp_valid_o); else npass++;
    ntot++; if (rsp_rdata_o !== 32'h0) $display("FAIL rst_rdata got %h exp 0", rsp_rdata_o); else npass++;
    ntot++; if (rsp_err_o !== 1'b0) $display("FAIL rst_err got %b exp 0", rsp_err_o); else npass++;
    ntot++; if ({mem_addr_o, mem_w_en_o, mem_w_sel_o, mem_w_data_o} !== '0)
      $display("FAIL rst_mem got %h/%b/%h/%h exp 0", mem_addr_o, mem_w_en_o, mem_w_sel_o, mem_w_data_o); else npass++;
    rst = 1'b0;
    #1;
    ntot++; if (req_ready_o !== 1'b1) $display("FAIL rst_release_ready got %b exp 1", req_ready_o); else npass++;
  endtask

  task automatic test_word_store;
    xfer(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    ntot++; if (lat !== e.lat) $display("FAIL wst_lat got %0d exp %0d", lat, e.lat); else npass++;
    ntot++; if (got_err !== e.err || got_rdata !== e.rdata) $display("FAIL wst_rsp got %b/%h exp %b/%h", got_err, got_rdata, e.err, e.rdata); else npass++;
    ntot++; if ({a_wen[0], a_addr[0], a_sel[0], a_data[0]} !== {1'b1, 32'h100, 4'hF, 32'hDEADBEEF})
      $display("FAIL wst_access got %b/%h/%h/%h exp 1/100/f/deadbeef", a_wen[0], a_addr[0], a_sel[0], a_data[0]); else npass++;
    finish_rsp();
    xfer(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 2);
    ntot++; if (got_rdata !== e.rdata || lat !== e.lat) $display("FAIL wld_readback got %h/%0d exp %h/%0d", got_rdata, lat, e.rdata, e.lat); else npass++;
    finish_rsp();
  endtask

  task automatic test_byte_load;
    logic [31:0] ta [5];
    logic [1:0] ts [5];
    logic tu [5];
    logic [31:0] te [5];
    ta = '{32'h203, 32'h203, 32'h202, 32'h201, 32'h200};
    ts = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd1};
    tu = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    te = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h0000007F, 32'h00007F01};
    store_word(32'h200, 32'h80FF7F01);
    for (int i = 0; i < 5; i++) begin
      xfer(1'b0, ts[i], tu[i], ta[i], 32'h0, te[i], 1'b0, 2);
      ntot++; if (got_rdata !== e.rdata || got_err !== e.err || lat !== e.lat)
        $display("FAIL load_%0d got %h/%b/%0d exp %h/%b/%0d", i, got_rdata, got_err, lat, e.rdata, e.err, e.lat); else npass++;
      finish_rsp();
    end
    xfer(1'b1, 2'd0, 1'b0, 32'h201, 32'h000000AB, 32'h0, 1'b0, 2);
    ntot++; if ({a_sel[0], a_data[0]} !== {4'b0010, 32'h0000AB00}) $display("FAIL bst_lane got %h/%h exp 2/0000ab00", a_sel[0], a_data[0]); else npass++;
    finish_rsp();
    xfer(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 32'h80FFAB01, 1'b0, 2);
    ntot++; if (got_rdata !== e.rdata) $display("FAIL bst_readback got %h exp %h", got_rdata, e.rdata); else npass++;
    finish_rsp();
  endtask

  task automatic test_split_store;
    int c0;
    store_word(32'h104, 32'h0);
    store_word(32'h108, 32'h0);
    c0 = wen_cnt;
    xfer(1'b1, 2'd2, 1'b0, 32'h105, 32'h11223344, 32'h0, !MIS, MIS ? 3 : 1);
    ntot++; if (lat !== e.lat || got_err !== e.err || got_rdata !== e.rdata)
      $display("FAIL sst_rsp got %0d/%b/%h exp %0d/%b/%h", lat, got_err, got_rdata, e.lat, e.err, e.rdata); else npass++;
    finish_rsp();
    if (MIS) begin
      ntot++; if ({a_wen[0], a_addr[0], a_sel[0], a_data[0]} !== {1'b1, 32'h104, 4'b1110, 32'h22334400})
        $display("FAIL sst_acc1 got %b/%h/%h/%h exp 1/104/e/22334400", a_wen[0], a_addr[0], a_sel[0], a_data[0]); else npass++;
      ntot++; if ({a_wen[1], a_addr[1], a_sel[1], a_data[1]} !== {1'b1, 32'h108, 4'b0001, 32'h00000011})
        $display("FAIL sst_acc2 got %b/%h/%h/%h exp 1/108/1/00000011", a_wen[1], a_addr[1], a_sel[1], a_data[1]); else npass++;
      xfer(1'b0, 2'd2, 1'b0, 32'h105, 32'h0, 32'h11223344, 1'b0, 3);
      ntot++; if (got_rdata !== e.rdata || lat !== e.lat) $display("FAIL sst_readback got %h/%0d exp %h/%0d", got_rdata, lat, e.rdata, e.lat); else npass++;
      finish_rsp();
    end else begin
      ntot++; if (wen_cnt !== c0) $display("FAIL sst_nowrite got %0d exp %0d", wen_cnt, c0); else npass++;
    end
    xfer(1'b0, 2'd2, 1'b0, 32'h104, 32'h0, MIS ? 32'h22334400 : 32'h0, 1'b0, 2);
    ntot++; if (got_rdata !== e.rdata) $display("FAIL sst_word104 got %h exp %h", got_rdata, e.rdata); else npass++;
    finish_rsp();
  endtask

  task automatic test_split_half_load;
    store_word(32'hFFFFFFFC, 32'h12345678);
    store_word(32'h0, 32'h9ABCDEF0);
    xfer(1'b0, 2'd1, 1'b0, 32'hFFFFFFFF, 32'h0, MIS ? 32'hFFFFF012 : 32'h0, !MIS, MIS ? 3 : 1);
    ntot++; if (got_rdata !== e.rdata || got_err !== e.err || lat !== e.lat)
      $display("FAIL shl_signed got %h/%b/%0d exp %h/%b/%0d", got_rdata, got_err, lat, e.rdata, e.err, e.lat); else npass++;
    if (MIS) begin
      ntot++; if ({a_addr[0], a_addr[1]} !== {32'hFFFFFFFC, 32'h0}) $display("FAIL shl_addrs got %h/%h exp fffffffc/0", a_addr[0], a_addr[1]); else npass++;
    end
    finish_rsp();
    xfer(1'b0, 2'd1, 1'b1, 32'hFFFFFFFF, 32'h0, MIS ? 32'h0000F012 : 32'h0, !MIS, MIS ? 3 : 1);
    ntot++; if (got_rdata !== e.rdata || got_err !== e.err || lat !== e.lat)
      $display("FAIL shl_unsigned got %h/%b/%0d exp %h/%b/%0d", got_rdata, got_err, lat, e.rdata, e.err, e.lat); else npass++;
    finish_rsp();
  endtask

  task automatic test_illegal;
    int c0;
    c0 = wen_cnt;
    xfer(1'b1, 2'd3, 1'b0, 32'h300, 32'hFFFFFFFF, 32'h0, 1'b1, 1);
    ntot++; if (got_err !== e.err || got_rdata !== e.rdata || lat !== e.lat)
      $display("FAIL ill_store got %b/%h/%0d exp %b/%h/%0d", got_err, got_rdata, lat, e.err, e.rdata, e.lat); else npass++;
    finish_rsp();
    ntot++; if (wen_cnt !== c0) $display("FAIL ill_nowrite got %0d exp %0d", wen_cnt, c0); else npass++;
    xfer(1'b0, 2'd3, 1'b0, 32'h200, 32'h0, 32'h0, 1'b1, 1);
    ntot++; if (got_err !== e.err || got_rdata !== e.rdata || lat !== e.lat)
      $display("FAIL ill_load got %b/%h/%0d exp %b/%h/%0d", got_err, got_rdata, lat, e.err, e.rdata, e.lat); else npass++;
    finish_rsp();
  endtask

  task automatic test_backpressure;
    xfer(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 32'h80FFAB01, 1'b0, 2);
    ntot++; if (got_rdata !== e.rdata) $display("FAIL bp_rdata got %h exp %h", got_rdata, e.rdata); else npass++;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      ntot++; if ({rsp_valid_o, req_ready_o, rsp_rdata_o} !== {1'b1, 1'b0, e.rdata})
        $display("FAIL bp_hold_%0d got %b/%b/%h exp 1/0/%h", i, rsp_valid_o, req_ready_o, rsp_rdata_o, e.rdata); else npass++;
    end
    finish_rsp();
    ntot++; if (req_ready_o !== 1'b1) $display("FAIL b2b_ready got %b exp 1", req_ready_o); else npass++;
    xfer(1'b0, 2'd0, 1'b1, 32'h202, 32'h0, 32'h000000FF, 1'b0, 2);
    ntot++; if (acc_wait !== 0 || got_rdata !== e.rdata) $display("FAIL b2b_second got %0d/%h exp 0/%h", acc_wait, got_rdata, e.rdata); else npass++;
    finish_rsp();
  endtask

  task automatic test_reset_mid;
    req_we_i = 1'b0; req_size_i = 2'd2; req_unsigned_i = 1'b0; req_addr_i = 32'h100; req_wdata_i = '0;
    req_valid_i = 1'b1;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    ntot++; if (mem_addr_o !== 32'h100) $display("FAIL rm_first_addr got %h exp 100", mem_addr_o); else npass++;
    rst = 1'b1;
    @(posedge clk); #1;
    ntot++; if ({req_ready_o, rsp_valid_o, rsp_err_o, rsp_rdata_o, mem_addr_o, mem_w_en_o, mem_w_sel_o, mem_w_data_o} !== '0)
      $display("FAIL rm_outputs got %b/%b/%b/%h/%h/%b/%h/%h exp 0", req_ready_o, rsp_valid_o, rsp_err_o, rsp_rdata_o, mem_addr_o, mem_w_en_o, mem_w_sel_o, mem_w_data_o); else npass++;
    rst = 1'b0;
    @(posedge clk); #1;
    ntot++; if ({req_ready_o, rsp_valid_o} !== 2'b10) $display("FAIL rm_idle got %b/%b exp 1/0", req_ready_o, rsp_valid_o); else npass++;
  endtask

  initial begin
    test_reset();
    test_word_store();
    test_byte_load();
    test_split_store();
    test_split_half_load();
    test_illegal();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Initiator side of the word-wide data RAM port: accepts byte/half/word load and store requests from the core's memory stage and converts them into RAM port accesses. It generates the word address, the byte-lane write strobes, lane-aligned write data, and sign/zero-extended load data. Accesses that straddle a word boundary are split into two RAM accesses. The block sits between the execute/memory pipeline stage and the `ram` peripheral.

## Interface

Parameters and macros:
- `WordBus` / `MemAddrBus` (from `buceros_header.v`, 32 bits each): data and address widths.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid_i` in 1: request valid.
- `req_ready_o` out 1: request accepted on any edge where valid and ready are both 1.
- `req_we_i` in 1: 1 = store, 0 = load.
- `req_size_i` in 2: 0 = byte, 1 = half, 2 = word, 3 = illegal.
- `req_unsigned_i` in 1: zero-extend loads when set.
- `req_addr_i` in 32: byte address.
- `req_wdata_i` in 32: store data, right-justified.
- `rsp_valid_o` out 1: response valid.
- `rsp_ready_i` in 1: response consumed on any edge where valid and ready are both 1.
- `rsp_rdata_o` out 32: extended load data; 0 for stores.
- `rsp_err_o` out 1: illegal size, or a split access when splitting is compiled out.
- `mem_addr_o` out 32: word-aligned RAM address (bits [1:0] = 0).
- `mem_w_en_o` out 1: RAM write enable.
- `mem_w_sel_o` out 4: byte-lane strobes; bit k controls bits [8k+7:8k].
- `mem_w_data_o` out 32: lane-aligned write data.
- `mem_r_data_i` in 32: RAM read data, combinational from `mem_addr_o`.

## Operation

- Little-endian: the byte at offset k lives in lane k.
- FSM states and transitions:
  - IDLE: `req_ready_o` = 1. On accept, latch the request and go to FIRST. An illegal size goes directly to RESP with err = 1.
  - FIRST: drive word `addr & ~3`. A load captures the relevant lanes of `mem_r_data_i`. A store asserts `mem_w_en_o`. A spanning access goes to SECOND; otherwise go to RESP.
  - SECOND: drive `(addr & ~3) + 4`, wrapping modulo 2^32. A load merges the remaining lanes. A store writes the remaining lanes. Then go to RESP.
  - RESP: hold `rsp_valid_o` = 1 and keep outputs stable until `rsp_ready_i`, then return to IDLE.
- A request spans when offset + size_bytes > 4: a half at offset 3, or a word at offset 1, 2 or 3.
- Strobes:
  - Byte: `1 << off`.
  - Half: `3 << off`, split across the boundary when spanning.
  - Word offset 1: first access `4'b1110` with data `wdata << 8`; second access `4'b0001` with data `wdata >> 24`.
  - All other spanning cases follow the same shift pattern.
- Loads: assemble bytes, then sign- or zero-extend from bit 7 (byte) or bit 15 (half).
- Outside FIRST/SECOND: `mem_w_en_o` = 0, `mem_w_sel_o` = 0, `mem_w_data_o` = 0, `mem_addr_o` = 0.

## Timing

- Reset values: state IDLE, `req_ready_o` = 0 while `rst` is high, `rsp_valid_o` = 0, `rsp_rdata_o` = 0, `rsp_err_o` = 0, all `mem_*` outputs = 0.
- Aligned access accepted at edge N:
  - RAM access during cycle N+1.
  - A store commits at edge N+2.
  - `rsp_valid_o` rises in cycle N+2.
- Split access: accesses in cycles N+1 and N+2, response in cycle N+3.
- Illegal size: response in cycle N+1; no `mem_w_en_o` pulse.
- Throughput: one request in flight. `req_ready_o` = 0 from accept until the response handshake. The next accept is possible in the cycle after the response handshake.
- Reset mid-operation: return to IDLE and drop the response. A first-half write that has already committed is not rolled back.

## Configuration

- `BUCEROS_LSU_MISALIGN_EN` defined: spanning accesses are split as described above.
- Undefined:
  - A spanning access skips FIRST and SECOND and goes IDLE -> RESP with `rsp_err_o` = 1 and `rsp_rdata_o` = 0.
  - No memory write occurs.
  - SECOND state logic is absent.

## Structure

- Shared header `buceros_header.v` holds:
  - The size encodings: `SizeByte`, `SizeHalf`, `SizeWord`.
  - The FSM state encodings.
  - The existing `WordBus`, `MemAddrBus` and `ZERO_WORD`.
- One combinational sub-module, `lsu_lane_align`, computes strobes, shifted write data and load extraction/extension from (offset, size, unsigned, phase).
- The FSM and registers live in `mem_access_unit`.

## Test plan

- Aligned word store: addr 0x100, data 0xDEADBEEF -> one access at 0x100, sel 4'hF; response in cycle N+2 with err 0.
- Byte load, signed and unsigned: memory word 0x80FF7F01 at 0x200; load byte at 0x203 -> 0xFFFFFF80 signed, 0x00000080 unsigned.
- Split word store (macro on): addr 0x105, data 0x11223344.
  - Access 1: 0x104, sel 4'b1110, data 0x22334400.
  - Access 2: 0x108, sel 4'b0001, data 0x00000011.
  - Reading back 0x105 returns 0x11223344.
- Split half load at 0xFFFFFFFF -> second access at 0x00000000, assembled in the correct lane order.
- Illegal size 3 or split with macro off -> err 1, rdata 0, no `mem_w_en_o` pulse, response in cycle N+1.
- `rsp_ready_i` held low 3 cycles -> response held stable, `req_ready_o` stays 0; `rst` asserted in FIRST -> all outputs return to reset values next cycle.
